// File: rtl/ppc_types.sv
// Shared PowerPC execution-unit types: decode controls, XER/CR0 update record
// and XER bit positions (LSB-indexed).
package ppc_types;

   localparam int unsigned XER_SO_BIT = 0;
   localparam int unsigned XER_OV_BIT = 1;

   typedef struct packed {
      logic mul_signed;
      logic mul_higher;
      logic alter_OV;
      logic alter_CR0;
   } mul_decode_t;

   typedef struct packed {
      logic [31:0] xer;
      logic        so;
      logic        xer_valid;
      logic        CR0_valid;
   } cond_exception_t;

endpackage

// File: rtl/elastic_pipe_ctrl.sv
// Valid/enable control for an elastic register pipeline: bubbles collapse under
// stall, one transfer per cycle per stage, optional flush clears all valids.
module elastic_pipe_ctrl #(
   parameter int unsigned STAGES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_ready,
   output logic [STAGES-1:0] valid,
   output logic [STAGES-1:0] enable
);

   if (STAGES < 2) begin : g_bad_stages
      $fatal(1, "elastic_pipe_ctrl: STAGES must be at least 2");
   end

   logic [STAGES:0]   en_chain;
   logic [STAGES-1:0] valid_prev;

   assign valid_prev = {valid[STAGES-2:0], in_valid};

   // Ready ripples back from the output, so evaluate from the last stage down.
   always_comb begin
      en_chain         = '0;
      en_chain[STAGES] = out_ready;
      for (int unsigned i = 0; i < STAGES; i++) begin
         en_chain[STAGES-1-i] = (~valid[STAGES-1-i] & valid_prev[STAGES-1-i])
                              | (valid[STAGES-1-i] & en_chain[STAGES-i]);
      end
   end

   assign enable   = en_chain[STAGES-1:0];
   assign in_ready = ~flush & (~valid[0] | en_chain[1]);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (en_chain[k]) valid[k] <= valid_prev[k];
         end
      end
   end

endmodule

// File: rtl/mul_unit_param.sv
// Elastic pipelined multiplier for mullw/mulhw/mulhwu/mullwo with XER/CR0 side info.
// Define MUL_UNIT_FLUSH_EN to add the flush port that kills all in-flight ops.
module mul_unit_param
   import ppc_types::*;
#(
   parameter int unsigned RS_ID_WIDTH = 5,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned STAGES      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef MUL_UNIT_FLUSH_EN
   input  logic                   flush,
`endif
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [RS_ID_WIDTH-1:0] rs_id_in,
   input  logic [4:0]             result_reg_addr_in,
   input  logic [DATA_WIDTH-1:0]  op1,
   input  logic [DATA_WIDTH-1:0]  op2,
   input  logic [31:0]            xer,
   input  mul_decode_t            control,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [RS_ID_WIDTH-1:0] rs_id_out,
   output logic [4:0]             result_reg_addr_out,
   output logic [DATA_WIDTH-1:0]  result,
   output cond_exception_t        cr0_xer
);

   if (DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
      $fatal(1, "mul_unit_param: DATA_WIDTH must be in 8..64");
   end
   if (STAGES < 3) begin : g_bad_stages
      $fatal(1, "mul_unit_param: STAGES must be at least 3");
   end

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned PW = 2 * W + 2;
   localparam int unsigned NP = (STAGES > 3) ? STAGES - 3 : 0;
   localparam int unsigned L  = STAGES - 2;

   logic                   kill;
   logic [STAGES-1:0]      valid;
   logic [STAGES-1:0]      enable;

`ifdef MUL_UNIT_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   elastic_pipe_ctrl #(.STAGES(STAGES)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .flush     (kill),
      .in_valid  (input_valid),
      .in_ready  (input_ready),
      .out_ready (output_ready),
      .valid     (valid),
      .enable    (enable)
   );

   assign output_valid = valid[STAGES-1];

   // Sideband for stages 0..STAGES-2; the last stage holds the output ports.
   logic [RS_ID_WIDTH-1:0] tag_q  [STAGES-1];
   logic [4:0]             addr_q [STAGES-1];
   logic [31:0]            xer_q  [STAGES-1];
   mul_decode_t            ctl_q  [STAGES-1];

   logic [W-1:0]           op_a_q, op_b_q;
   logic [W:0]             ext_a_q, ext_b_q;
   logic [PW-1:0]          mul_a, mul_b, product, prod_fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES - 1; k++) begin
            tag_q[k]  <= '0;
            addr_q[k] <= '0;
            xer_q[k]  <= '0;
            ctl_q[k]  <= '0;
         end
         op_a_q  <= '0;
         op_b_q  <= '0;
         ext_a_q <= '0;
         ext_b_q <= '0;
      end else begin
         if (enable[0]) begin
            tag_q[0]  <= rs_id_in;
            addr_q[0] <= result_reg_addr_in;
            xer_q[0]  <= xer;
            ctl_q[0]  <= control;
            op_a_q    <= op1;
            op_b_q    <= op2;
         end
         if (enable[1]) begin
            ext_a_q <= {ctl_q[0].mul_signed & op_a_q[W-1], op_a_q};
            ext_b_q <= {ctl_q[0].mul_signed & op_b_q[W-1], op_b_q};
         end
         for (int unsigned k = 1; k < STAGES - 1; k++) begin
            if (enable[k]) begin
               tag_q[k]  <= tag_q[k-1];
               addr_q[k] <= addr_q[k-1];
               xer_q[k]  <= xer_q[k-1];
               ctl_q[k]  <= ctl_q[k-1];
            end
         end
      end
   end

   // W+1-bit operands already carry signedness, so a plain PW-bit product is exact.
   assign mul_a   = {{(W+1){ext_a_q[W]}}, ext_a_q};
   assign mul_b   = {{(W+1){ext_b_q[W]}}, ext_b_q};
   assign product = mul_a * mul_b;

   if (NP > 0) begin : g_prod_pipe
      logic [PW-1:0] prod_q [NP];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int unsigned j = 0; j < NP; j++) prod_q[j] <= '0;
         end else begin
            if (enable[2]) prod_q[0] <= product;
            for (int unsigned j = 1; j < NP; j++) begin
               if (enable[j+2]) prod_q[j] <= prod_q[j-1];
            end
         end
      end

      assign prod_fin = prod_q[NP-1];
   end else begin : g_prod_comb
      assign prod_fin = product;
   end

   logic            ov;
   logic [W-1:0]    res_c;
   logic [31:0]     xer_c;
   cond_exception_t ce_c;

   always_comb begin
      if (ctl_q[L].mul_signed)
         ov = ~((&prod_fin[PW-1:W-1]) | ~(|prod_fin[PW-1:W-1]));
      else
         ov = |prod_fin[PW-1:W];
      res_c = ctl_q[L].mul_higher ? prod_fin[2*W-1:W] : prod_fin[W-1:0];
      xer_c = xer_q[L];
      if (ctl_q[L].alter_OV) begin
         xer_c[XER_OV_BIT] = ov;
         xer_c[XER_SO_BIT] = xer_q[L][XER_SO_BIT] | ov;
      end
      ce_c.xer       = xer_c;
      ce_c.so        = xer_c[XER_SO_BIT];
      ce_c.xer_valid = ctl_q[L].alter_OV;
      ce_c.CR0_valid = ctl_q[L].alter_CR0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rs_id_out           <= '0;
         result_reg_addr_out <= '0;
         result              <= '0;
         cr0_xer             <= '0;
      end else if (enable[STAGES-1]) begin
         rs_id_out           <= tag_q[L];
         result_reg_addr_out <= addr_q[L];
         result              <= res_c;
         cr0_xer             <= ce_c;
      end
   end

endmodule

// File: tb/tb_mul_unit_param.sv
// Self-checking bench for mul_unit_param: arithmetic reference model, queue scoreboard,
// directed corner cases, backpressure, mid-op reset and (with MUL_UNIT_FLUSH_EN) flush.
module tb_mul_unit_param;
   import ppc_types::*;

   localparam int unsigned W  = 32;
   localparam int unsigned S  = 4;
   localparam int unsigned RW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            input_valid, input_ready, output_valid, output_ready;
   logic [RW-1:0]   rs_id_in, rs_id_out;
   logic [4:0]      result_reg_addr_in, result_reg_addr_out;
   logic [W-1:0]    op1, op2, result;
   logic [31:0]     xer;
   mul_decode_t     control;
   cond_exception_t cr0_xer;
   logic            fl_sig;
`ifdef MUL_UNIT_FLUSH_EN
   logic            flush;
   assign fl_sig = flush;
`else
   assign fl_sig = 1'b0;
`endif

   always #5 clk = ~clk;

   mul_unit_param #(.RS_ID_WIDTH(RW), .DATA_WIDTH(W), .STAGES(S)) dut (
      .clk                 (clk),
      .rst                 (rst),
`ifdef MUL_UNIT_FLUSH_EN
      .flush               (flush),
`endif
      .input_valid         (input_valid),
      .input_ready         (input_ready),
      .rs_id_in            (rs_id_in),
      .result_reg_addr_in  (result_reg_addr_in),
      .op1                 (op1),
      .op2                 (op2),
      .xer                 (xer),
      .control             (control),
      .output_valid        (output_valid),
      .output_ready        (output_ready),
      .rs_id_out           (rs_id_out),
      .result_reg_addr_out (result_reg_addr_out),
      .result              (result),
      .cr0_xer             (cr0_xer)
   );

   typedef struct packed {
      logic [RW-1:0]   id;
      logic [4:0]      addr;
      logic [W-1:0]    res;
      cond_exception_t ce;
   } exp_t;

   exp_t            q[$];
   int              n_tests = 0;
   int              n_fail  = 0;
   int              acc_cnt = 0;
   int              out_cnt = 0;
   logic [RW-1:0]   tag_ctr = '0;
   logic [W-1:0]    last_res;
   cond_exception_t last_ce;
   logic            prev_stall = 1'b0;
   logic            prev_kill  = 1'b1;
   logic [RW+W-1:0] held;
   logic            done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: full-precision product from plain integer arithmetic.
   function automatic exp_t model(input logic [RW-1:0] id, input logic [4:0] a,
                                  input logic [W-1:0] o1, input logic [W-1:0] o2,
                                  input logic [31:0] x, input mul_decode_t c);
      exp_t        e;
      longint      sp;
      logic [63:0] p;
      logic        ov;
      if (c.mul_signed) begin
         sp = longint'($signed(o1)) * longint'($signed(o2));
         p  = sp;
         ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      end else begin
         p  = {32'd0, o1} * {32'd0, o2};
         ov = (p > 64'h0000_0000_FFFF_FFFF);
      end
      e.id     = id;
      e.addr   = a;
      e.res    = c.mul_higher ? p[63:32] : p[31:0];
      e.ce.xer = x;
      if (c.alter_OV) begin
         e.ce.xer[1] = ov;
         e.ce.xer[0] = x[0] | ov;
      end
      e.ce.so        = e.ce.xer[0];
      e.ce.xer_valid = c.alter_OV;
      e.ce.CR0_valid = c.alter_CR0;
      return e;
   endfunction

   function automatic mul_decode_t dec(input logic s, input logic h, input logic o, input logic c0);
      mul_decode_t d;
      d.mul_signed = s;
      d.mul_higher = h;
      d.alter_OV   = o;
      d.alter_CR0  = c0;
      return d;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h0000_0001;
         2:       return '1;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Inputs are stable at the falling edge, so handshakes seen here take effect at the next rise.
   always @(negedge clk) begin
      exp_t e;
      if (prev_stall && !prev_kill) begin
         check("hold_valid", output_valid, 1);
         check("hold_data", {rs_id_out, result}, held);
      end
      if (rst) begin
         q.delete();
      end else begin
         if (output_valid && output_ready) begin
            out_cnt++;
            last_res = result;
            last_ce  = cr0_xer;
            if (q.size() == 0) begin
               check("spurious_out", 64'(q.size()), 1);
            end else begin
               e = q.pop_front();
               check("rs_id", rs_id_out, e.id);
               check("addr", result_reg_addr_out, e.addr);
               check("result", result, e.res);
               check("cr0_xer", cr0_xer, e.ce);
            end
         end
         if (fl_sig) begin
            check("flush_in_rdy", input_ready, 0);
            q.delete();
         end else if (input_valid && input_ready) begin
            acc_cnt++;
            q.push_back(model(rs_id_in, result_reg_addr_in, op1, op2, xer, control));
         end
      end
      prev_stall = output_valid && !output_ready;
      prev_kill  = rst || fl_sig;
      held       = {rs_id_out, result};
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input mul_decode_t c, input logic [31:0] x);
      int unsigned n = 0;
      rs_id_in           = tag_ctr;
      result_reg_addr_in = 5'($urandom);
      op1                = a;
      op2                = b;
      control            = c;
      xer                = x;
      input_valid        = 1'b1;
      @(negedge clk);
      while (!input_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!input_ready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      input_valid = 1'b0;
      tag_ctr++;
   endtask

   task automatic drain();
      int unsigned n = 0;
      output_ready = 1'b1;
      while (q.size() != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("drain", 64'(q.size()), 0);
   endtask

   task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b,
                       input mul_decode_t c, input logic [31:0] x);
      send(a, b, c, x);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic latency_check(input string tag);
      int unsigned n = 0;
      output_ready = 1'b1;
      send(32'd1234, 32'd5678, dec(0, 0, 0, 0), 32'h0);
      do begin
         @(negedge clk);
         n++;
      end while (!output_valid && n < 20);
      check(tag, n, 4);
      drain();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0, out0;
      rst = 1'b1;
      input_valid = 1'b0;
      output_ready = 1'b1;
      rs_id_in = '0;
      result_reg_addr_in = '0;
      op1 = '0;
      op2 = '0;
      xer = '0;
      control = '0;
`ifdef MUL_UNIT_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ovalid", output_valid, 0);
      check("rst_result", result, 0);
      check("rst_cr0_xer", cr0_xer, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      latency_check("latency");

      run1(32'hFFFF_FFFF, 32'hFFFF_FFFF, dec(0, 1, 0, 0), 32'h0);
      check("umul_hi", last_res, 32'hFFFF_FFFE);
      run1(32'hFFFF_FFFF, 32'hFFFF_FFFF, dec(0, 0, 0, 0), 32'h0);
      check("umul_lo", last_res, 32'h0000_0001);
      run1(32'h7FFF_FFFF, 32'h0000_0002, dec(1, 0, 1, 0), 32'h0);
      check("ov_res", last_res, 32'hFFFF_FFFE);
      check("ov_xer", last_ce.xer, 32'h0000_0003);
      check("ov_so", last_ce.so, 1);
      check("ov_xval", last_ce.xer_valid, 1);
      run1(32'hFFFF_FFFE, 32'h0000_0003, dec(1, 0, 1, 1), 32'h0000_0003);
      check("nov_res", last_res, 32'hFFFF_FFFA);
      check("nov_xer", last_ce.xer, 32'h0000_0001);
      check("nov_so", last_ce.so, 1);
      check("nov_cr0v", last_ce.CR0_valid, 1);
      run1(32'hFFFF_FFFF, 32'h0000_0001, dec(1, 1, 0, 0), 32'h0);
      check("smul_hi", last_res, 32'hFFFF_FFFF);

      // Backpressure: 8 back-to-back ops into a stalled pipe.
      acc0 = acc_cnt;
      out0 = out_cnt;
      output_ready = 1'b0;
      fork
         for (int i = 0; i < 8; i++)
            send(pick(), pick(), mul_decode_t'($urandom_range(0, 15)), $urandom);
         begin
            repeat (6) @(negedge clk);
            check("bp_accepts", acc_cnt - acc0, 4);
            check("bp_in_ready", input_ready, 0);
            @(posedge clk);
            #1;
            output_ready = 1'b1;
         end
      join
      drain();
      check("bp_outputs", out_cnt - out0, 8);
      @(posedge clk);
      #1;

      // Randomized traffic with random downstream stalls.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(pick(), pick(), mul_decode_t'($urandom_range(0, 15)), $urandom);
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1'b1;
         end
         while (!done) begin
            @(posedge clk);
            #1;
            output_ready = ($urandom_range(0, 3) != 0);
         end
      join
      drain();
      @(posedge clk);
      #1;

      // Reset with three ops in flight.
      output_ready = 1'b0;
      out0 = out_cnt;
      for (int i = 0; i < 3; i++) send(pick(), pick(), dec(0, 0, 0, 0), $urandom);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_ovalid", output_valid, 0);
      check("rstmid_result", result, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      output_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("rstmid_stale", output_valid, 0);
      check("rstmid_outs", out_cnt - out0, 0);
      @(posedge clk);
      #1;

`ifdef MUL_UNIT_FLUSH_EN
      output_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(pick(), pick(), dec(1, 0, 1, 0), $urandom);
      check("fl_full", output_valid, 1);
      flush = 1'b1;
      rs_id_in = tag_ctr;
      op1 = 32'd3;
      op2 = 32'd7;
      control = dec(0, 0, 0, 0);
      input_valid = 1'b1;
      @(negedge clk);
      check("fl_in_ready", input_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      input_valid = 1'b0;
      @(negedge clk);
      check("fl_ovalid", output_valid, 0);
      repeat (6) @(negedge clk);
      check("fl_stale", output_valid, 0);
      @(posedge clk);
      #1;
      latency_check("fl_latency");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
